// File: rtl/imem_load_ctrl_if.sv
// Bundle of every signal the instruction-memory load controller exchanges
// with its surroundings: the loader byte stream, the fetch-stage handshake,
// the memory write/read ports and the status flags.
//   master : controller side (drives ld_ready, fetch returns, memory controls)
//   slave  : environment side (loader, fetch stage, memory array)
interface imem_load_ctrl_if #(
  parameter int CNT_W = 11
);
  // Loader stream
  logic             ld_start;
  logic             ld_valid;
  logic             ld_ready;
  logic [63:0]      ld_addr;
  logic [7:0]       ld_data;
  logic             ld_last;
  // Fetch stage
  logic             f_req;
  logic [63:0]      f_pc;
  logic             f_valid;
  logic             f_stall;
  // Memory array
  logic             mem_wEn;
  logic [63:0]      mem_waddr;
  logic [7:0]       mem_wdata;
  logic [63:0]      mem_PC;
  logic             imem_err;
  // Status
  logic             run;
  logic             load_err;
  logic             fetch_err;
  logic [CNT_W-1:0] ld_count;

  modport master (
    input  ld_start, ld_valid, ld_addr, ld_data, ld_last,
    input  f_req, f_pc, imem_err,
    output ld_ready, f_valid, f_stall,
    output mem_wEn, mem_waddr, mem_wdata, mem_PC,
    output run, load_err, fetch_err, ld_count
  );

  modport slave (
    output ld_start, ld_valid, ld_addr, ld_data, ld_last,
    output f_req, f_pc, imem_err,
    input  ld_ready, f_valid, f_stall,
    input  mem_wEn, mem_waddr, mem_wdata, mem_PC,
    input  run, load_err, fetch_err, ld_count
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory sequencer. Shares the byte-addressed instruction memory
// between the program loader (one byte per accepted transfer) and the fetch
// stage (one FETCH_BYTES window at PC). Fetch is held off until a load ends
// with ld_last, then the core runs; a fetch that the memory flags as out of
// range traps into FAULT until the next ld_start.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : imem_load_ctrl_if.master (loader, fetch, memory, status signals)
module imem_load_ctrl #(
  parameter int MEM_BYTES   = 1025,
  parameter int FETCH_BYTES = 10,
  parameter int CNT_W       = 11
) (
  input logic               clk,
  input logic               rst_n,
  imem_load_ctrl_if.master  bus
);

  // The memory computes imem_err from mem_PC itself; the window size only
  // has to make sense relative to the memory size.
  if (FETCH_BYTES < 1 || FETCH_BYTES > MEM_BYTES) begin : g_bad_fetch_window
    $error("imem_load_ctrl: FETCH_BYTES must be within 1..MEM_BYTES");
  end

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FAULT
  } state_t;

  state_t state;
  logic   pending;
  logic   accept;
  logic   in_range;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ld_start pre-empts the byte offered in the same cycle.
  assign bus.ld_ready = (state == LOAD) && !bus.ld_start;
  assign accept       = bus.ld_ready && bus.ld_valid;
  assign in_range     = bus.ld_addr < MEM_LIMIT;

  // Read data is valid in the cycle after the request, unless the memory
  // flags the window as out of range or a new load aborts the fetch.
  assign bus.f_valid  = pending && !bus.imem_err && !bus.ld_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      bus.f_stall   <= 1'b1;
      bus.mem_wEn   <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_PC    <= '0;
      bus.run       <= 1'b0;
      bus.load_err  <= 1'b0;
      bus.fetch_err <= 1'b0;
      bus.ld_count  <= '0;
    end else begin
      bus.mem_wEn <= 1'b0;
      if (bus.ld_start) begin
        state         <= LOAD;
        pending       <= 1'b0;
        bus.f_stall   <= 1'b1;
        bus.run       <= 1'b0;
        bus.load_err  <= 1'b0;
        bus.fetch_err <= 1'b0;
        bus.ld_count  <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (in_range) begin
                bus.mem_wEn   <= 1'b1;
                bus.mem_waddr <= bus.ld_addr;
                bus.mem_wdata <= bus.ld_data;
              end else begin
                bus.load_err  <= 1'b1;
              end
              bus.ld_count <= sat_inc(bus.ld_count);
              if (bus.ld_last) begin
                state       <= RUN;
                bus.run     <= 1'b1;
                bus.f_stall <= 1'b0;
              end
            end
          end
          RUN: begin
            if (pending) begin
              pending <= 1'b0;
              if (bus.imem_err) begin
                state         <= FAULT;
                bus.run       <= 1'b0;
                bus.fetch_err <= 1'b1;
                bus.f_stall   <= 1'b1;
              end else begin
                bus.f_stall   <= 1'b0;
              end
            end else if (bus.f_req) begin
              pending     <= 1'b1;
              bus.mem_PC  <= bus.f_pc;
              bus.f_stall <= 1'b1;
            end
          end
          default: begin
            // IDLE and FAULT wait for ld_start.
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Sequencer that owns access to the byte-addressed instruction memory and shares it between the program loader (byte-wide write stream) and the fetch stage (10-byte read window at PC). It holds fetch off while a program is being loaded, then releases the processor to run, registering fetch returns and trapping out-of-range accesses. It sits between the loader/testbench, the fetch logic and the instruction memory array.

Parameters:
MEM_BYTES, 1025, number of bytes in the instruction memory (valid addresses 0..MEM_BYTES-1)
FETCH_BYTES, 10, bytes per fetch window (opcode byte + 9 following bytes)
CNT_W, 11, width of the loaded-byte counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
ld_start  in  1  single-cycle pulse: begin a new program load
ld_valid  in  1  loader byte valid
ld_ready  out  1  controller accepts loader byte this cycle
ld_addr  in  64  target byte address
ld_data  in  8  byte to write
ld_last  in  1  marks final byte of program, qualified by ld_valid&ld_ready
f_req  in  1  fetch request, level, from fetch stage
f_pc  in  64  PC of requested fetch
f_valid  out  1  fetch data returned from memory is valid this cycle
f_stall  out  1  fetch must hold PC (not RUN, or request outstanding)
mem_wEn  out  1  memory byte write enable
mem_waddr  out  64  memory write address
mem_wdata  out  8  memory write data
mem_PC  out  64  read address presented to memory
imem_err  in  1  memory range error for mem_PC
run  out  1  high in RUN state
load_err  out  1  sticky: loader address out of range during last load
fetch_err  out  1  sticky: fetch faulted
ld_count  out  CNT_W  bytes written in current/last load (saturates at all-ones)

Behaviour:
- States: IDLE, LOAD, RUN, FAULT. Reset (rst_n=0 at edge): state=IDLE; ld_ready=0, f_valid=0, f_stall=1, mem_wEn=0, mem_waddr=0, mem_wdata=0, mem_PC=0, run=0, load_err=0, fetch_err=0, ld_count=0. Reset mid-load or mid-fetch discards everything; partially written memory is not cleared.
- IDLE: ld_start -> LOAD. Fetch requests ignored (f_stall=1, f_valid=0).
- LOAD: ld_ready=1 combinationally. On ld_valid&ld_ready: if ld_addr<MEM_BYTES, registered write next cycle (mem_wEn=1, mem_waddr/mem_wdata = captured values, exactly one cycle); else no write, load_err<=1. ld_count increments per accepted byte regardless of range. Accepted byte with ld_last -> RUN (write of that byte still issued the following cycle). ld_last without ld_valid ignored.
- ld_start in any state (including LOAD): -> LOAD, ld_count<=0, load_err<=0, fetch_err<=0, any outstanding fetch aborted (no f_valid). ld_start wins over ld_valid in the same cycle; that byte is not accepted (ld_ready=0 when ld_start=1).
- RUN: run=1, ld_ready=0. Fetch is 1-cycle latency: cycle N f_req=1 with f_stall=0 -> mem_PC<=f_pc, request outstanding; cycle N+1 f_stall=1, f_valid=1 if imem_err=0. If imem_err=1 in N+1: f_valid=0, fetch_err<=1, -> FAULT. Back-to-back fetches: one every 2 cycles (request, return). f_stall=0 only in RUN with no outstanding request.
- Range rule: imem_err is asserted by memory when mem_PC+FETCH_BYTES-1 >= MEM_BYTES; controller does not recompute it.
- FAULT: run=0, f_stall=1, f_valid=0; leaves only via ld_start or reset.
- mem_PC holds last value when not fetching. No writes ever issued outside LOAD-accept path.

Test Plan:
- Reset: drive rst_n=0 two cycles mid-LOAD -> all outputs at reset values, state IDLE, f_req=1 yields f_stall=1, f_valid=0.
- Load 42 bytes at addresses 0..41, ld_last on byte 41 -> 42 one-cycle mem_wEn pulses with matching addr/data, ld_count=42, run=1 the cycle after the last accept, load_err=0.
- Loader byte at ld_addr=1025 -> no mem_wEn, load_err=1, ld_count still increments; next ld_start clears load_err.
- RUN, f_req=1 f_pc=26 -> next cycle mem_PC=26, f_valid=1, f_stall=1; following cycle f_stall=0; continuous f_req gives f_valid every other cycle.
- RUN, f_pc=1020 with memory returning imem_err=1 -> f_valid=0, fetch_err=1, state FAULT, f_stall=1 held; ld_start -> LOAD, fetch_err=0.
- ld_start coincident with ld_valid and with outstanding fetch -> byte not accepted (ld_ready=0), no f_valid, ld_count=0, state LOAD.
